// File: rtl/pet_status_fsm_pkg.sv
// Shared types and helpers for the pet status stage and its neighbours.
package pet_status_fsm_pkg;

    localparam int LVL_W = 3;

    // Bit positions of the buttons inside the packed button vector.
    localparam int BTN_FEED = 0;
    localparam int BTN_HEAL = 1;
    localparam int BTN_CHG  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EATING  = 3'd1,
        ST_HEALING = 3'd2,
        ST_SICK    = 3'd3,
        ST_DEAD    = 3'd4
    } pet_state_e;

    // One step up (clamped at max_lvl) or down (clamped at 0).
    function automatic logic [LVL_W-1:0] lvl_step(input logic [LVL_W-1:0] lvl,
                                                  input logic             up,
                                                  input logic [LVL_W-1:0] max_lvl);
        if (up) begin
            return (lvl >= max_lvl) ? max_lvl : lvl + 1'b1;
        end
        return (lvl == LVL_W'(0)) ? LVL_W'(0) : lvl - 1'b1;
    endfunction

endpackage

// File: rtl/pet_status_fsm_if.sv
// Button levels in, pet status out; master is the driving stage, slave the pet logic.
interface pet_status_fsm_if
    import pet_status_fsm_pkg::*;
();
    logic             feeding;
    logic             healing;
    logic             change;
    logic             test_sig;
    logic [LVL_W-1:0] satiety;
    logic [LVL_W-1:0] health;
    logic [2:0]       pet_state;
    logic             page;
    logic             tick;

    modport master (
        output feeding, healing, change, test_sig,
        input  satiety, health, pet_state, page, tick
    );

    modport slave (
        input  feeding, healing, change, test_sig,
        output satiety, health, pet_state, page, tick
    );
endinterface

// File: rtl/pet_status_fsm_tick_gen.sv
// Time-base prescaler: one tick every P cycles, P chosen by test mode,
// restarting from zero whenever the mode changes.
module pet_status_fsm_tick_gen #(
    parameter int TICK_CYCLES      = 50_000_000,
    parameter int TEST_TICK_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic test_sig_i,
    output logic tick_o
);
    localparam int MAX_P = (TICK_CYCLES > TEST_TICK_CYCLES) ? TICK_CYCLES : TEST_TICK_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last_cnt;
    logic          test_q;
    logic          tick_q, tick_d;

    assign last_cnt = test_sig_i ? CW'(TEST_TICK_CYCLES - 1) : CW'(TICK_CYCLES - 1);

    // Next count: restart on mode change, otherwise wrap at P-1 and flag a tick.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (test_sig_i != test_q) begin
            cnt_d = '0;
        end else if (cnt_q >= last_cnt) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Counter, previous mode and tick registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            test_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            test_q <= test_sig_i;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
endmodule

// File: rtl/pet_status_fsm.sv
// Pet behaviour core: press detection, satiety/health decay and the mood FSM.
module pet_status_fsm
    import pet_status_fsm_pkg::*;
#(
    parameter int TICK_CYCLES      = 50_000_000,
    parameter int TEST_TICK_CYCLES = 5_000_000,
    parameter int DECAY_TICKS      = 10,
    parameter int ANIM_TICKS       = 2,
    parameter int MAX_LVL          = 5
) (
    input  logic            clk,
    input  logic            rst,
    pet_status_fsm_if.slave bus
);
    localparam int               DW         = $clog2(DECAY_TICKS + 1);
    localparam int               AW         = $clog2(ANIM_TICKS + 1);
    localparam logic [LVL_W-1:0] MAX_L      = LVL_W'(MAX_LVL);
    localparam logic [DW-1:0]    DECAY_LAST = DW'(DECAY_TICKS - 1);
    localparam logic [AW-1:0]    ANIM_LAST  = AW'(ANIM_TICKS - 1);

    logic [2:0]       btn_in, btn_q, press_q;
    logic             tick;
    logic             decay;
    pet_state_e       state_q, state_d;
    logic [LVL_W-1:0] sat_q, sat_d, hea_q, hea_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [AW-1:0]    acnt_q, acnt_d;
    logic             page_q, page_d;

    assign btn_in = {bus.change, bus.healing, bus.feeding};

    pet_status_fsm_tick_gen #(
        .TICK_CYCLES      (TICK_CYCLES),
        .TEST_TICK_CYCLES (TEST_TICK_CYCLES)
    ) u_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .test_sig_i (bus.test_sig),
        .tick_o     (tick)
    );

    // Register button levels and turn each 0->1 transition into a one-cycle press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q   <= '0;
            press_q <= '0;
        end else begin
            btn_q   <= btn_in;
            press_q <= btn_in & ~btn_q;
        end
    end

    // Next state and levels: decay first, then press increment, with health==0 forcing DEAD.
    always_comb begin
        state_d = state_q;
        sat_d   = sat_q;
        hea_d   = hea_q;
        dcnt_d  = dcnt_q;
        acnt_d  = acnt_q;
        page_d  = page_q ^ press_q[BTN_CHG];
        decay   = 1'b0;

        if (state_q != ST_DEAD && tick) begin
            if (dcnt_q == DECAY_LAST) begin
                dcnt_d = '0;
                decay  = 1'b1;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        // Hunger drains first; health only suffers once satiety is exhausted.
        if (decay) begin
            if (sat_q != LVL_W'(0)) sat_d = lvl_step(sat_q, 1'b0, MAX_L);
            else                    hea_d = lvl_step(hea_q, 1'b0, MAX_L);
        end

        case (state_q)
            ST_IDLE, ST_SICK: begin
                if (hea_q == LVL_W'(0)) begin
                    state_d = ST_DEAD;
                end else if (press_q[BTN_FEED]) begin
                    state_d = ST_EATING;
                    sat_d   = lvl_step(sat_d, 1'b1, MAX_L);
                    acnt_d  = '0;
                end else if (press_q[BTN_HEAL]) begin
                    state_d = ST_HEALING;
                    hea_d   = lvl_step(hea_d, 1'b1, MAX_L);
                    acnt_d  = '0;
                end else if (hea_q <= LVL_W'(1)) begin
                    state_d = ST_SICK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EATING, ST_HEALING: begin
                if (hea_q == LVL_W'(0)) begin
                    state_d = ST_DEAD;
                end else if (tick) begin
                    if (acnt_q == ANIM_LAST) begin
                        acnt_d  = '0;
                        state_d = (hea_q <= LVL_W'(1)) ? ST_SICK : ST_IDLE;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_DEAD;
            end
        endcase
    end

    // State, level, counter and page registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sat_q   <= MAX_L;
            hea_q   <= MAX_L;
            dcnt_q  <= '0;
            acnt_q  <= '0;
            page_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sat_q   <= sat_d;
            hea_q   <= hea_d;
            dcnt_q  <= dcnt_d;
            acnt_q  <= acnt_d;
            page_q  <= page_d;
        end
    end

    assign bus.satiety   = sat_q;
    assign bus.health    = hea_q;
    assign bus.pet_state = state_q;
    assign bus.page      = page_q;
    assign bus.tick      = tick;
endmodule

// File: tb/tb_pet_status_fsm.sv
// Randomized bench for pet_status_fsm against a cycle-level behavioural model.
module tb_pet_status_fsm;
    localparam int TICK_CYCLES      = 10;
    localparam int TEST_TICK_CYCLES = 2;
    localparam int DECAY_TICKS      = 3;
    localparam int ANIM_TICKS       = 2;
    localparam int MAX_LVL          = 5;

    localparam int M_IDLE = 0, M_EAT = 1, M_HEAL = 2, M_SICK = 3, M_DEAD = 4;

    logic clk = 1'b0;
    logic rst;

    pet_status_fsm_if bus();

    pet_status_fsm #(
        .TICK_CYCLES      (TICK_CYCLES),
        .TEST_TICK_CYCLES (TEST_TICK_CYCLES),
        .DECAY_TICKS      (DECAY_TICKS),
        .ANIM_TICKS       (ANIM_TICKS),
        .MAX_LVL          (MAX_LVL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: expected outputs after the most recent rising edge.
    bit     m_valid = 1'b0;
    int     m_sat, m_hea, m_st, m_page, m_tick;
    int     m_run;          // edges since the time base last restarted
    int     m_alive_ticks;  // ticks seen while alive since reset
    int     m_anim;         // ticks seen in the current animation
    bit     m_prev_test;
    bit [2:0] m_b1, m_b2;   // button levels sampled one and two edges ago

    task automatic check(input string tag, input integer got, input integer exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit r, input bit f, input bit h, input bit c, input bit t);
        bit [2:0] press;
        int       tick_seen;
        int       old_hea;
        int       period;
        if (!r) begin
            m_sat = MAX_LVL; m_hea = MAX_LVL; m_st = M_IDLE; m_page = 0; m_tick = 0;
            m_run = 0; m_alive_ticks = 0; m_anim = 0; m_prev_test = 1'b0;
            m_b1 = '0; m_b2 = '0; m_valid = 1'b1;
            return;
        end
        press = m_b1 & ~m_b2;
        m_b2  = m_b1;
        m_b1  = {c, h, f};

        tick_seen = m_tick;
        period    = t ? TEST_TICK_CYCLES : TICK_CYCLES;
        if (t != m_prev_test) begin
            m_run  = 0;
            m_tick = 0;
        end else begin
            m_run++;
            m_tick = (m_run % period == 0) ? 1 : 0;
        end
        m_prev_test = t;

        if (press[2]) m_page = 1 - m_page;
        if (m_st == M_DEAD) return;

        old_hea = m_hea;
        if (tick_seen == 1) begin
            m_alive_ticks++;
            if (m_alive_ticks % DECAY_TICKS == 0) begin
                if (m_sat > 0)      m_sat--;
                else if (m_hea > 0) m_hea--;
            end
        end

        if (old_hea == 0) begin
            m_st = M_DEAD;
        end else if (m_st == M_IDLE || m_st == M_SICK) begin
            if (press[0]) begin
                m_st = M_EAT;
                if (m_sat < MAX_LVL) m_sat++;
                m_anim = 0;
            end else if (press[1]) begin
                m_st = M_HEAL;
                if (m_hea < MAX_LVL) m_hea++;
                m_anim = 0;
            end else begin
                m_st = (old_hea <= 1) ? M_SICK : M_IDLE;
            end
        end else if (tick_seen == 1) begin
            m_anim++;
            if (m_anim == ANIM_TICKS) m_st = (old_hea <= 1) ? M_SICK : M_IDLE;
        end
    endtask

    // One clock: compare outputs of the last edge, drive new inputs, advance the model.
    task automatic step(input bit r, input bit f, input bit h, input bit c, input bit t);
        @(negedge clk);
        if (m_valid) begin
            check("satiety",   bus.satiety,   m_sat);
            check("health",    bus.health,    m_hea);
            check("pet_state", bus.pet_state, m_st);
            check("page",      bus.page,      m_page);
            check("tick",      bus.tick,      m_tick);
        end
        rst          = r;
        bus.feeding  = f;
        bus.healing  = h;
        bus.change   = c;
        bus.test_sig = t;
        model_edge(r, f, h, c, t);
        cyc++;
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    initial begin
        bit cur_t;
        int len, pct;
        rst = 1'b0;
        bus.feeding = 1'b0; bus.healing = 1'b0; bus.change = 1'b0; bus.test_sig = 1'b0;

        // Reset, then idle in normal mode: ticks at 10 and 20, levels stay full.
        $display("phase reset-idle");
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (25) step(1, 0, 0, 0, 0);

        // Feed held from reset: a single press, saturated satiety.
        $display("phase feed-held");
        step(0, 1, 0, 0, 0);
        repeat (50) step(1, 1, 0, 0, 0);

        // Starve in test mode until DEAD, then poke it.
        $display("phase starve-dead");
        step(0, 0, 0, 0, 1);
        repeat (100) step(1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, (i % 2 == 0), 1);
        step(1, 1, 0, 0, 1); step(1, 0, 0, 0, 1);
        step(1, 0, 1, 0, 1); step(1, 0, 0, 0, 1);
        repeat (6) step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (4) step(1, 0, 0, 0, 0);

        // Reach SICK, then simultaneous feed+heal, then heal alone.
        $display("phase sick-presses");
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 200 && m_st != M_SICK; i++) step(1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        repeat (6) step(1, 0, 0, 0, 1);
        step(1, 0, 1, 0, 1);
        repeat (12) step(1, 0, 0, 0, 1);

        // Mode switch at prescaler count 7 in normal mode.
        $display("phase mode-switch");
        step(0, 0, 0, 0, 0);
        repeat (7) step(1, 0, 0, 0, 0);
        repeat (20) step(1, 0, 0, 0, 1);

        // Randomized phases with occasional resets and mode toggles.
        cur_t = 1'b0;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(120, 40);
            pct = $urandom_range(35);
            $display("phase random %0d len=%0d press_pct=%0d", p, len, pct);
            if (chance(15)) step(0, chance(50), chance(50), 0, cur_t);
            for (int i = 0; i < len; i++) begin
                if (chance(3)) cur_t = ~cur_t;
                step(1, chance(pct), chance(pct), chance(pct), cur_t);
            end
        end

        step(1, 0, 0, 0, cur_t);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
